mult_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one multshift8bits shift-add multiplier among N_REQ requesters. It accepts 8-bit operand pairs over a REQ/GNT handshake, launches the multiplier, waits for its ready, and returns the 16-bit product tagged with the requester ID. It sits between client blocks and a single multiplier instance and guards against a hung multiplier with a timeout.

---
 rtl/mult_share_arbiter_pkg.sv | 20 ++
 rtl/mult_share_arbiter_rr_pick.sv | 48 ++++
 rtl/mult_share_arbiter.sv | 157 +++++++++++++++
 tb/tb_mult_share_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_share_arbiter_pkg.sv
// Shared definitions for the multiplier-sharing arbiter: widths, FSM encoding, helpers.
package mult_share_arbiter_pkg;

    localparam int unsigned OPND_W = 8;
    localparam int unsigned PROD_W = 16;

    typedef logic [2:0] state_t;

    localparam state_t StIdle   = 3'd0;
    localparam state_t StLaunch = 3'd1;
    localparam state_t StSettle = 3'd2;
    localparam state_t StWait   = 3'd3;
    localparam state_t StFinish = 3'd4;

    // Increment modulo n without a divider.
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/mult_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, else lowest set request.
module mult_share_arbiter_rr_pick
    import mult_share_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  idx,
    output logic             any
);

    logic            any_hi;
    logic            any_lo;
    logic [ID_W-1:0] idx_hi;
    logic [ID_W-1:0] idx_lo;

    // Two priority scans: one restricted to indices >= ptr, one over all requests.
    always_comb begin
        any_hi = 1'b0;
        any_lo = 1'b0;
        idx_hi = '0;
        idx_lo = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req[i] && !any_lo) begin
                any_lo = 1'b1;
                idx_lo = ID_W'(i);
            end
            if (req[i] && (ID_W'(i) >= ptr) && !any_hi) begin
                any_hi = 1'b1;
                idx_hi = ID_W'(i);
            end
        end
    end

    // Wrap-around falls back to the unrestricted scan; grant is the one-hot of the winner.
    always_comb begin
        any = any_lo;
        idx = any_hi ? idx_hi : idx_lo;
        gnt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            gnt[i] = any_lo && (idx == ID_W'(i));
        end
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one shift-add multiplier among N_REQ clients,
// with a WAIT-state timeout guarding against a hung multiplier.
module mult_share_arbiter
    import mult_share_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [N_REQ-1:0]        REQ,
    input  logic [OPND_W*N_REQ-1:0] A,
    input  logic [OPND_W*N_REQ-1:0] B,
    output logic [N_REQ-1:0]        GNT,
    output logic                    DONE,
    output logic [PROD_W-1:0]       RESULT,
    output logic [ID_W-1:0]         RESULT_ID,
    output logic                    ERR,
    output logic [OPND_W-1:0]       MUL_M1,
    output logic [OPND_W-1:0]       MUL_M2,
    output logic                    MUL_START,
    input  logic                    MUL_READY,
    input  logic [PROD_W-1:0]       MUL_RESULT,
    output logic                    BUSY
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

    state_t              state_q;
    state_t              state_d;
    logic [ID_W-1:0]     ptr_q;
    logic [ID_W-1:0]     id_q;
    logic [OPND_W-1:0]   m1_q;
    logic [OPND_W-1:0]   m2_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [PROD_W-1:0]   result_q;
    logic [ID_W-1:0]     result_id_q;
    logic                err_q;

    logic [N_REQ-1:0]    pick_gnt;
    logic [ID_W-1:0]     pick_idx;
    logic                pick_any;
    logic [OPND_W-1:0]   a_sel;
    logic [OPND_W-1:0]   b_sel;
    logic                accept;
    logic                timed_out;

    mult_share_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .req (REQ),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign accept    = (state_q == StIdle) && pick_any;
    // Ready has priority: timeout only matters when ready is absent this cycle.
    assign timed_out = (state_q == StWait) && !MUL_READY && (cnt_q == CntLast);

    // Operand slice mux for the winning requester.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx == ID_W'(i)) begin
                a_sel = A[i*OPND_W +: OPND_W];
                b_sel = B[i*OPND_W +: OPND_W];
            end
        end
    end

    // Next-state logic for the launch/settle/wait sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (pick_any) state_d = StLaunch;
            StLaunch: state_d = StSettle;
            StSettle: state_d = StWait;
            StWait:   if (MUL_READY || timed_out) state_d = StFinish;
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture operands, served index and advance the round-robin pointer on accept.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ptr_q <= '0;
            id_q  <= '0;
            m1_q  <= '0;
            m2_q  <= '0;
        end else if (accept) begin
            ptr_q <= ID_W'(wrap_inc(32'(pick_idx), N_REQ));
            id_q  <= pick_idx;
            m1_q  <= a_sel;
            m2_q  <= b_sel;
        end
    end

    // Timeout counter: cleared in SETTLE, counts every WAIT cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q <= '0;
        end else if (state_q == StSettle) begin
            cnt_q <= '0;
        end else if (state_q == StWait && !MUL_READY && !timed_out) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Result registers update only when leaving WAIT and hold between DONE pulses.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            result_q    <= '0;
            result_id_q <= '0;
            err_q       <= 1'b0;
        end else if (state_q == StWait && MUL_READY) begin
            result_q    <= MUL_RESULT;
            result_id_q <= id_q;
            err_q       <= 1'b0;
        end else if (timed_out) begin
            result_q    <= '0;
            result_id_q <= id_q;
            err_q       <= 1'b1;
        end
    end

    // State-decoded pulses, forced low while reset is asserted.
    always_comb begin
        GNT       = '0;
        if (accept && !RESET) GNT = pick_gnt;
        MUL_START = (state_q == StLaunch) && !RESET;
        DONE      = (state_q == StFinish) && !RESET;
        BUSY      = (state_q != StIdle) && !RESET;
    end

    assign MUL_M1    = m1_q;
    assign MUL_M2    = m2_q;
    assign RESULT    = result_q;
    assign RESULT_ID = result_id_q;
    assign ERR       = err_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Scoreboard bench for mult_share_arbiter with a behavioural shift-add multiplier model.
module tb_mult_share_arbiter;

    localparam int N_REQ   = 4;
    localparam int ID_W    = 2;
    localparam int TIMEOUT = 64;
    localparam int LAT     = 8;

    typedef struct packed {
        logic [15:0] res;
        logic [1:0]  id;
        logic        err;
    } exp_t;

    logic               CLK = 1'b0;
    logic               RESET = 1'b1;
    logic [N_REQ-1:0]   REQ = '0;
    logic [8*N_REQ-1:0] A = '0;
    logic [8*N_REQ-1:0] B = '0;
    logic [N_REQ-1:0]   GNT;
    logic               DONE;
    logic [15:0]        RESULT;
    logic [ID_W-1:0]    RESULT_ID;
    logic               ERR;
    logic [7:0]         MUL_M1;
    logic [7:0]         MUL_M2;
    logic               MUL_START;
    logic               MUL_READY = 1'b1;
    logic [15:0]        MUL_RESULT = 16'hBEEF;
    logic               BUSY;

    int total = 0;
    int bad = 0;

    exp_t       exp_q[$];
    logic [3:0] gnt_q[$];

    logic       mul_hang = 1'b0;
    logic       start_d = 1'b0;
    int         lat_cnt = 0;
    logic [15:0] prod = '0;

    mult_share_arbiter #(
        .N_REQ   (N_REQ),
        .ID_W    (ID_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .REQ        (REQ),
        .A          (A),
        .B          (B),
        .GNT        (GNT),
        .DONE       (DONE),
        .RESULT     (RESULT),
        .RESULT_ID  (RESULT_ID),
        .ERR        (ERR),
        .MUL_M1     (MUL_M1),
        .MUL_M2     (MUL_M2),
        .MUL_START  (MUL_START),
        .MUL_READY  (MUL_READY),
        .MUL_RESULT (MUL_RESULT),
        .BUSY       (BUSY)
    );

    always #5 CLK = ~CLK;

    // Multiplier model: ready (with a stale product) stays high one cycle past the start
    // pulse, then drops and returns LAT cycles later unless hung.
    always @(posedge CLK) begin
        start_d <= MUL_START;
        if (start_d) begin
            MUL_READY <= 1'b0;
            lat_cnt   <= LAT;
            prod      <= 16'(MUL_M1) * 16'(MUL_M2);
        end else if (lat_cnt != 0) begin
            lat_cnt <= lat_cnt - 1;
            if (lat_cnt == 1 && !mul_hang) begin
                MUL_READY  <= 1'b1;
                MUL_RESULT <= prod;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every DONE and every GNT is compared against the scoreboard queues.
    always @(negedge CLK) begin
        exp_t e;
        logic [3:0] g;
        if (DONE === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(DONE), 0);
            end else begin
                e = exp_q.pop_front();
                check("result", 32'(RESULT), 32'(e.res));
                check("result_id", 32'(RESULT_ID), 32'(e.id));
                check("err", 32'(ERR), 32'(e.err));
            end
        end
        if (GNT !== 4'b0000) begin
            if (gnt_q.size() == 0) begin
                check("unexpected_gnt", 32'(GNT), 0);
            end else begin
                g = gnt_q.pop_front();
                check("gnt", 32'(GNT), 32'(g));
            end
        end
    end

    task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
        A[8*i +: 8] = a;
        B[8*i +: 8] = b;
    endtask

    // Raise REQ[i] and return at the negedge of the grant cycle.
    task automatic request(input int i, input logic [7:0] a, input logic [7:0] b);
        int k;
        set_ops(i, a, b);
        REQ[i] = 1'b1;
        k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (GNT[i] !== 1'b1 && k < 200);
        if (GNT[i] !== 1'b1) check("grant_seen", 0, 1);
    endtask

    // One full operation; n = cycles from the grant cycle to the DONE cycle.
    task automatic serve(input int i, input logic [7:0] a, input logic [7:0] b, output int n);
        request(i, a, b);
        @(posedge CLK);
        #1 REQ[i] = 1'b0;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
            if (n == 1) check("start_pulse", 32'(MUL_START), 1);
            if (n == 2) check("start_width", 32'(MUL_START), 0);
        end while (DONE !== 1'b1 && n < 300);
        if (DONE !== 1'b1) check("done_seen", 0, 1);
    endtask

    task automatic wait_empty();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || gnt_q.size() != 0) && k < 400) begin
            @(negedge CLK);
            k++;
        end
        if (k >= 400) check("drain_timeout", 32'(exp_q.size()), 0);
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1 RESET = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"}, 32'(GNT), 0);
        check({tag, "_done"}, 32'(DONE), 0);
        check({tag, "_busy"}, 32'(BUSY), 0);
        check({tag, "_start"}, 32'(MUL_START), 0);
        check({tag, "_result"}, 32'(RESULT), 0);
        check({tag, "_id"}, 32'(RESULT_ID), 0);
        check({tag, "_err"}, 32'(ERR), 0);
        check({tag, "_m1"}, 32'(MUL_M1), 0);
        check({tag, "_m2"}, 32'(MUL_M2), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got time %0t expected finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int g;
        int k;

        // Reset: a pending request must not be granted while RESET is high.
        REQ[0] = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("gnt_in_reset", 32'(GNT), 0);
        check("start_in_reset", 32'(MUL_START), 0);
        #1 REQ[0] = 1'b0;
        @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        check_all_zero("reset");

        // Single request 5*4; stale ready from the model must be ignored in SETTLE.
        @(posedge CLK);
        #1;
        gnt_q.push_back(4'b0001);
        exp_q.push_back('{res: 16'd20, id: 2'd0, err: 1'b0});
        serve(0, 8'd5, 8'd4, n);
        check("done_latency", 32'(n), 32'(LAT + 4));
        wait_empty();

        // Max operands on requester 1.
        gnt_q.push_back(4'b0010);
        exp_q.push_back('{res: 16'd65025, id: 2'd1, err: 1'b0});
        serve(1, 8'd255, 8'd255, n);
        wait_empty();

        // Contention 0101 from reset: 0 then 2, with 2 granted right after 0's DONE.
        do_reset();
        gnt_q.push_back(4'b0001);
        gnt_q.push_back(4'b0100);
        exp_q.push_back('{res: 16'd21, id: 2'd0, err: 1'b0});
        exp_q.push_back('{res: 16'd120, id: 2'd2, err: 1'b0});
        set_ops(0, 8'd3, 8'd7);
        set_ops(2, 8'd10, 8'd12);
        REQ = 4'b0101;
        k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (GNT[0] !== 1'b1 && k < 50);
        @(posedge CLK);
        #1 REQ[0] = 1'b0;
        k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (DONE !== 1'b1 && k < 100);
        @(negedge CLK);
        check("gnt2_after_done", 32'(GNT), 32'(4'b0100));
        @(posedge CLK);
        #1 REQ[2] = 1'b0;
        wait_empty();

        // Fairness: all requests held for 8 grants.
        do_reset();
        for (int i = 0; i < N_REQ; i++) set_ops(i, 8'(i + 1), 8'(i + 2));
        for (int r = 0; r < 2; r++) begin
            gnt_q.push_back(4'b0001);
            gnt_q.push_back(4'b0010);
            gnt_q.push_back(4'b0100);
            gnt_q.push_back(4'b1000);
            exp_q.push_back('{res: 16'd2, id: 2'd0, err: 1'b0});
            exp_q.push_back('{res: 16'd6, id: 2'd1, err: 1'b0});
            exp_q.push_back('{res: 16'd12, id: 2'd2, err: 1'b0});
            exp_q.push_back('{res: 16'd20, id: 2'd3, err: 1'b0});
        end
        REQ = 4'b1111;
        g = 0;
        k = 0;
        while (g < 8 && k < 400) begin
            @(negedge CLK);
            k++;
            if (GNT !== 4'b0000) g++;
        end
        check("fair_grants", 32'(g), 8);
        @(posedge CLK);
        #1 REQ = 4'b0000;
        wait_empty();

        // Timeout: hung multiplier, requester 3 with 7*9.
        mul_hang = 1'b1;
        gnt_q.push_back(4'b1000);
        exp_q.push_back('{res: 16'd0, id: 2'd3, err: 1'b1});
        serve(3, 8'd7, 8'd9, n);
        check("timeout_latency", 32'(n), 32'(TIMEOUT + 3));
        @(negedge CLK);
        check("idle_after_timeout", 32'(BUSY), 0);
        wait_empty();

        // Reset during WAIT: no DONE, everything cleared, then 3*3 on requester 2.
        gnt_q.push_back(4'b0001);
        request(0, 8'd11, 8'd13);
        @(posedge CLK);
        #1 REQ[0] = 1'b0;
        repeat (10) @(posedge CLK);
        @(negedge CLK);
        check("busy_in_wait", 32'(BUSY), 1);
        @(posedge CLK);
        #1 RESET = 1'b1;
        @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        check_all_zero("midreset");
        repeat (80) @(negedge CLK);
        mul_hang = 1'b0;
        @(posedge CLK);
        #1;
        gnt_q.push_back(4'b0100);
        exp_q.push_back('{res: 16'd9, id: 2'd2, err: 1'b0});
        serve(2, 8'd3, 8'd3, n);
        wait_empty();

        check("sb_results_drained", 32'(exp_q.size()), 0);
        check("sb_grants_drained", 32'(gnt_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
